// File: rtl/cpc_ram1m_pkg.sv
// Shared types and constants for the 1MB CPC RAM expansion controller:
// access FSM states, config encodings, gate-array port match and page mapping.
package cpc_ram1m_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_B3P3,
        C_ALL,
        C_B3P3_REMAP,
        C_B1P0,
        C_B1P1,
        C_B1P2,
        C_B1P3
    } cfg_t;

    localparam logic [1:0] PORT_D76 = 2'b11;
    localparam logic       PORT_A15 = 1'b0;

    // Returns {hit, page[1:0]} for a Z80 16K block under a given config.
    // Config 3 would remap internal blocks; only its block-3 part is honoured.
    function automatic logic [2:0] page_map(input logic [2:0] cfg, input logic [1:0] blk);
        logic [2:0] r;
        r = 3'b000;
        case (cfg_t'(cfg))
            C_B3P3, C_B3P3_REMAP:           r = {blk == 2'd3, 2'd3};
            C_ALL:                          r = {1'b1, blk};
            C_B1P0, C_B1P1, C_B1P2, C_B1P3: r = {blk == 2'd1, cfg[1:0]};
            default:                        r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpc_ram1m_cfgreg.sv
// Snoops Z80 OUT cycles to the gate-array RAM config port and latches cfg/bank
// once per I/O write, using a registered rising-edge detect on the port match.
module cpc_ram1m_cfgreg #(
    parameter int BANK_W = 4
) (
    input  logic              CLK,
    input  logic              RESET_B,
    input  logic              a15,
    input  logic              a8,
    input  logic [7:0]        D,
    input  logic              IOREQ_B,
    input  logic              WR_B,
    input  logic              M1_B,
    input  logic              dip512,
    output logic [2:0]        cfg,
    output logic [BANK_W-1:0] bank
);
    import cpc_ram1m_pkg::*;

    logic port_hit;
    logic port_hit_q;

    assign port_hit = ~IOREQ_B & ~WR_B & M1_B & (a15 == PORT_A15) & (D[7:6] == PORT_D76);

    // &7Exx selects the upper 512K chip unless the board is strapped for 512K.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            port_hit_q <= 1'b0;
            cfg        <= '0;
            bank       <= '0;
        end else begin
            port_hit_q <= port_hit;
            if (port_hit && !port_hit_q) begin
                cfg  <= D[2:0];
                bank <= {~a8 & ~dip512, D[3 +: BANK_W-1]};
            end
        end
    end

endmodule

// File: rtl/cpc_ram1m_ctrl.sv
// Top of the 1MB expansion CPLD: block/page decode, combinational RAMDIS and
// the SRAM access sequencer driving chip selects, OE/WE and the high address.
module cpc_ram1m_ctrl #(
    parameter int BANK_W  = 4,
    parameter int HIADR_W = 5
) (
    input  logic               CLK,
    input  logic               RESET_B,
    input  logic [15:0]        A,
    input  logic [7:0]         D,
    input  logic               MREQ_B,
    input  logic               IOREQ_B,
    input  logic               RD_B,
    input  logic               WR_B,
    input  logic               M1_B,
    input  logic               RFSH_B,
    input  logic               RAMRD_B,
    input  logic [3:0]         dip,
    output logic               RAMDIS,
    output logic               RAMCS0_B,
    output logic               RAMCS1_B,
    output logic               RAMOE_B,
    output logic               RAMWE_B,
    output logic [HIADR_W-1:0] HIADR
);
    import cpc_ram1m_pkg::*;

    logic [2:0]        cfg;
    logic [BANK_W-1:0] bank;
    logic [2:0]        map;
    logic              hit;
    state_t            state;
    logic              unused_inputs;

    cpc_ram1m_cfgreg #(.BANK_W(BANK_W)) u_cfgreg (
        .CLK     (CLK),
        .RESET_B (RESET_B),
        .a15     (A[15]),
        .a8      (A[8]),
        .D       (D),
        .IOREQ_B (IOREQ_B),
        .WR_B    (WR_B),
        .M1_B    (M1_B),
        .dip512  (dip[1]),
        .cfg     (cfg),
        .bank    (bank)
    );

    assign map = page_map(cfg, A[15:14]);
    assign hit = dip[0] & map[2];

    // Unregistered so the internal RAM is disabled before its own decode fires.
    assign RAMDIS = hit & ~MREQ_B & RFSH_B;

    assign unused_inputs = ^{RD_B, dip[3:2], A[13:9], A[7:0]};

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state    <= IDLE;
            RAMCS0_B <= 1'b1;
            RAMCS1_B <= 1'b1;
            RAMOE_B  <= 1'b1;
            RAMWE_B  <= 1'b1;
            HIADR    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!MREQ_B && RFSH_B && hit) begin
                        state    <= ACCESS;
                        HIADR    <= {bank[HIADR_W-3:0], map[1:0]};
                        RAMCS0_B <= bank[BANK_W-1];
                        RAMCS1_B <= ~bank[BANK_W-1];
                    end
                end
                ACCESS: begin
                    if (MREQ_B) begin
                        state    <= IDLE;
                        RAMCS0_B <= 1'b1;
                        RAMCS1_B <= 1'b1;
                        RAMOE_B  <= 1'b1;
                        RAMWE_B  <= 1'b1;
                    end else begin
                        // A write wins: never let the SRAM drive the bus while WE is low.
                        RAMWE_B <= WR_B;
                        RAMOE_B <= RAMRD_B | ~WR_B;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpc_ram1m_ctrl.sv
// Directed bench for cpc_ram1m_ctrl: a behavioural model checked every cycle,
// plus literal expectations from the hand-worked bus scenarios.
module tb_cpc_ram1m_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D = 8'h00;
    logic        MREQ_B = 1'b1, IOREQ_B = 1'b1, RD_B = 1'b1, WR_B = 1'b1;
    logic        M1_B = 1'b1, RFSH_B = 1'b1, RAMRD_B = 1'b1;
    logic [3:0]  dip = 4'b0001;
    logic        RAMDIS, RAMCS0_B, RAMCS1_B, RAMOE_B, RAMWE_B;
    logic [4:0]  HIADR;

    int checks = 0;
    int failures = 0;

    cpc_ram1m_ctrl dut (
        .CLK(CLK), .RESET_B(RESET_B), .A(A), .D(D),
        .MREQ_B(MREQ_B), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
        .M1_B(M1_B), .RFSH_B(RFSH_B), .RAMRD_B(RAMRD_B), .dip(dip),
        .RAMDIS(RAMDIS), .RAMCS0_B(RAMCS0_B), .RAMCS1_B(RAMCS1_B),
        .RAMOE_B(RAMOE_B), .RAMWE_B(RAMWE_B), .HIADR(HIADR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: latched configuration plus the state of the SRAM access in flight.
    int m_cfg = 0, m_bank = 0, m_hiadr = 0, m_chip = 0;
    bit m_prev = 0, m_act = 0, m_oe = 1, m_we = 1;

    function automatic bit bench_map(input int cfg, input int blk, output int page);
        page = 0;
        if (cfg == 2) begin page = blk; return 1'b1; end
        if (cfg == 1 || cfg == 3) begin page = 3; return blk == 3; end
        if (cfg >= 4) begin page = cfg - 4; return blk == 1; end
        return 1'b0;
    endfunction

    always @(posedge CLK or negedge RESET_B) begin : model
        bit cond;
        bit h;
        int pg;
        if (!RESET_B) begin
            m_cfg = 0; m_bank = 0; m_hiadr = 0; m_chip = 0;
            m_prev = 0; m_act = 0; m_oe = 1; m_we = 1;
        end else begin
            cond = !IOREQ_B && !WR_B && M1_B && !A[15] && (D[7:6] == 2'b11);
            h = bench_map(m_cfg, int'(A[15:14]), pg);
            if (!m_act) begin
                if (!MREQ_B && RFSH_B && dip[0] && h) begin
                    m_act = 1;
                    m_hiadr = (m_bank % 8) * 4 + pg;
                    m_chip = m_bank / 8;
                end
            end else if (MREQ_B) begin
                m_act = 0; m_oe = 1; m_we = 1;
            end else begin
                m_we = WR_B;
                m_oe = WR_B ? RAMRD_B : 1'b1;
            end
            if (cond && !m_prev) begin
                m_cfg = int'(D[2:0]);
                m_bank = int'(D[5:3]) + ((!A[8] && !dip[1]) ? 8 : 0);
            end
            m_prev = cond;
        end
    end

    always @(negedge CLK) begin : compare
        bit h;
        int pg;
        h = bench_map(m_cfg, int'(A[15:14]), pg);
        check("model RAMDIS", 8'(RAMDIS), 8'(dip[0] && h && !MREQ_B && RFSH_B));
        check("model RAMCS0_B", 8'(RAMCS0_B), 8'(!(m_act && m_chip == 0)));
        check("model RAMCS1_B", 8'(RAMCS1_B), 8'(!(m_act && m_chip == 1)));
        check("model RAMOE_B", 8'(RAMOE_B), 8'(m_oe));
        check("model RAMWE_B", 8'(RAMWE_B), 8'(m_we));
        check("model HIADR", 8'(HIADR), 8'(m_hiadr));
    end

    // All stimulus changes land 3 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    task automatic io_out(input logic [15:0] addr, input logic [7:0] data);
        A = addr; D = data; IOREQ_B = 1'b0; WR_B = 1'b0; M1_B = 1'b1;
        tick(2);
        IOREQ_B = 1'b1; WR_B = 1'b1; D = 8'h00;
        tick(1);
    endtask

    task automatic mem_rd(input logic [15:0] addr);
        A = addr; MREQ_B = 1'b0; RD_B = 1'b0; RAMRD_B = 1'b0; RFSH_B = 1'b1;
    endtask

    task automatic mem_wr(input logic [15:0] addr, input logic [7:0] data);
        A = addr; D = data; MREQ_B = 1'b0; WR_B = 1'b0; RFSH_B = 1'b1;
    endtask

    task automatic mem_idle();
        MREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1; RAMRD_B = 1'b1; RFSH_B = 1'b1;
    endtask

    initial begin
        // Reset held for three clocks
        tick(3);
        check("reset RAMCS0_B", 8'(RAMCS0_B), 8'h01);
        check("reset RAMCS1_B", 8'(RAMCS1_B), 8'h01);
        check("reset RAMOE_B", 8'(RAMOE_B), 8'h01);
        check("reset RAMWE_B", 8'(RAMWE_B), 8'h01);
        check("reset RAMDIS", 8'(RAMDIS), 8'h00);
        check("reset HIADR", 8'(HIADR), 8'h00);
        RESET_B = 1'b1;
        tick(1);
        mem_rd(16'h4000);
        tick(2);
        check("c0 read CS0", 8'(RAMCS0_B), 8'h01);
        check("c0 read RAMDIS", 8'(RAMDIS), 8'h00);
        mem_idle();
        tick(1);

        // cfg c2, bank 0: read &4000 -> page 1 on chip 0
        io_out(16'h7F00, 8'hC2);
        mem_rd(16'h4000);
        tick(2);
        check("c2 read RAMDIS", 8'(RAMDIS), 8'h01);
        check("c2 read CS0", 8'(RAMCS0_B), 8'h00);
        check("c2 read CS1", 8'(RAMCS1_B), 8'h01);
        check("c2 read HIADR", 8'(HIADR), 8'b00001);
        check("c2 read OE", 8'(RAMOE_B), 8'h00);
        mem_idle();
        tick(1);
        check("c2 end OE", 8'(RAMOE_B), 8'h01);
        check("c2 end CS0", 8'(RAMCS0_B), 8'h01);
        check("c2 end HIADR held", 8'(HIADR), 8'b00001);

        // &7E00,&FC: bank 15, cfg c4; write &4123 -> chip 1, HIADR 11100
        io_out(16'h7E00, 8'hFC);
        mem_wr(16'h4123, 8'h55);
        tick(2);
        check("c4 write CS1", 8'(RAMCS1_B), 8'h00);
        check("c4 write CS0", 8'(RAMCS0_B), 8'h01);
        check("c4 write HIADR", 8'(HIADR), 8'b11100);
        check("c4 write WE", 8'(RAMWE_B), 8'h00);
        check("c4 write OE", 8'(RAMOE_B), 8'h01);
        mem_idle();
        tick(1);

        // Held I/O strobe latches once: D changes while held are ignored
        A = 16'h7F00; D = 8'hC2; IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(1);
        D = 8'hC1;
        tick(2);
        IOREQ_B = 1'b1; WR_B = 1'b1; D = 8'h00;
        tick(1);
        mem_rd(16'h0000);
        tick(2);
        check("held io still c2 RAMDIS", 8'(RAMDIS), 8'h01);
        check("held io still c2 HIADR", 8'(HIADR), 8'b00000);
        mem_idle();
        tick(1);

        // Refresh at &C000 under c2 is never claimed
        A = 16'hC000; MREQ_B = 1'b0; RFSH_B = 1'b0;
        tick(2);
        check("refresh RAMDIS", 8'(RAMDIS), 8'h00);
        check("refresh CS0", 8'(RAMCS0_B), 8'h01);
        mem_idle();
        tick(1);

        // 512K strap: bank[3] forced low, chip 0 only
        dip = 4'b0011;
        io_out(16'h7E00, 8'hFC);
        mem_rd(16'h4000);
        tick(2);
        check("512k CS0", 8'(RAMCS0_B), 8'h00);
        check("512k CS1", 8'(RAMCS1_B), 8'h01);
        check("512k HIADR", 8'(HIADR), 8'b11100);
        mem_idle();
        tick(1);

        // Expansion disabled: config still latched, nothing claimed
        dip = 4'b0000;
        io_out(16'h7F00, 8'hC2);
        mem_rd(16'h0000);
        tick(2);
        check("disabled RAMDIS", 8'(RAMDIS), 8'h00);
        check("disabled CS0", 8'(RAMCS0_B), 8'h01);
        mem_idle();
        tick(1);
        dip = 4'b0001;
        mem_rd(16'h0000);
        tick(2);
        check("reenabled RAMDIS", 8'(RAMDIS), 8'h01);
        check("reenabled CS0", 8'(RAMCS0_B), 8'h00);
        mem_idle();
        tick(1);

        // cfg c1, async reset mid-read of &C000
        io_out(16'h7F00, 8'hC1);
        mem_rd(16'hC000);
        tick(2);
        check("c1 read CS0", 8'(RAMCS0_B), 8'h00);
        check("c1 read HIADR", 8'(HIADR), 8'b00011);
        check("c1 read OE", 8'(RAMOE_B), 8'h00);
        #1;
        RESET_B = 1'b0;
        #1;
        check("async reset CS0", 8'(RAMCS0_B), 8'h01);
        check("async reset OE", 8'(RAMOE_B), 8'h01);
        check("async reset RAMDIS", 8'(RAMDIS), 8'h00);
        tick(1);
        RESET_B = 1'b1;
        tick(1);
        mem_idle();
        tick(1);
        mem_rd(16'hC000);
        tick(2);
        check("post reset RAMDIS", 8'(RAMDIS), 8'h00);
        check("post reset CS0", 8'(RAMCS0_B), 8'h01);
        mem_idle();
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
